// File: rtl/decoder_pkg.sv
// Shared types and constants for the 3-to-8 decoder line scanner.
package decoder_pkg;

    localparam int SEL_W     = 3;
    localparam int NUM_LINES = 2 ** SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // First line driven in a sweep: 0 when sweeping up, top line when sweeping down.
    function automatic logic [SEL_W-1:0] first_line(input logic mode_down);
        return mode_down ? SEL_W'(NUM_LINES - 1) : '0;
    endfunction

    function automatic logic [SEL_W-1:0] last_line(input logic mode_down);
        return mode_down ? '0 : SEL_W'(NUM_LINES - 1);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter that times how long each decoder line stays selected.
module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // load has priority; dec never underflows because the caller only decrements when nonzero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_line_scanner.sv
// Sequencer driving a 3-to-8 decoder's select and enable so that each line is held for a dwell time.
module decoder_line_scanner
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_down,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               line_done,
    output logic               sweep_done,
    output state_t             dbg_state
);

    // start is a level sampled only in IDLE; stop is a level that aborts RUN on the edge it is
    // sampled and also blocks a start seen on the same edge. There is no handshake back.

    state_t             state;
    logic               mode_q;
    logic               cont_q;
    logic [DWELL_W-1:0] dw_q;
    logic [DWELL_W-1:0] dw_eff;
    logic [DWELL_W-1:0] cnt;
    logic               cnt_zero;
    logic               launch;
    logic               step;
    logic               cnt_load;
    logic               cnt_dec;
    logic [DWELL_W-1:0] cnt_load_val;

    assign dw_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign launch   = (state == IDLE) && start && !stop;
    assign step     = (state == RUN) && !stop && cnt_zero;
    assign cnt_load = launch || step;
    assign cnt_dec  = (state == RUN) && !stop && !cnt_zero;

    // A fresh sweep uses the live dwell input; later lines reuse the latched value.
    assign cnt_load_val = launch ? (dw_eff - DWELL_W'(1)) : (dw_q - DWELL_W'(1));

    dwell_counter #(
        .W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            cont_q     <= 1'b0;
            dw_q       <= DWELL_W'(1);
            sel        <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            line_done  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        mode_q <= mode_down;
                        cont_q <= continuous;
                        dw_q   <= dw_eff;
                        sel    <= first_line(mode_down);
                        en     <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        line_done <= 1'b1;
                        if (sel != last_line(mode_q)) begin
                            sel <= mode_q ? sel - SEL_W'(1) : sel + SEL_W'(1);
                        end else begin
                            sweep_done <= 1'b1;
                            if (cont_q) begin
                                sel <= first_line(mode_q);
                            end else begin
                                en    <= 1'b0;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
